// File: rtl/cpri_pkt_framer.sv
// CPRI TX packet framer: drains one whole PKT_LEN packet from a show-ahead FIFO as a burst.
// Optional in-band header beat carrying the sequence number when CPRI_PKT_HDR_EN is defined.
module cpri_pkt_framer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned PKT_LEN    = 32,
    parameter int unsigned SEQ_WIDTH  = 16,
    localparam int unsigned UW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic [UW-1:0]         fifo_usedw,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_valid,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    input  logic                  pkt_ready,
    output logic [SEQ_WIDTH-1:0]  pkt_seq,
    output logic                  underrun_err
);

    localparam int unsigned AW = UW + 1;
    localparam int unsigned CW = $clog2(PKT_LEN);

    typedef enum logic {StIdle, StPayload} state_e;

    state_e               state;
    logic [CW-1:0]        word_cnt;
    logic                 load_en;
    logic                 start;
    logic                 last_word;
    logic                 eop_accept;
    logic [AW-1:0]        avail;
    logic [SEQ_WIDTH-1:0] seq_next;

    assign load_en    = !pkt_valid | pkt_ready;
    // usedw wraps to 0 when the FIFO is full, so full must stand in for the depth.
    assign avail      = fifo_full ? AW'(FIFO_DEPTH) : {1'b0, fifo_usedw};
    assign last_word  = (word_cnt == CW'(PKT_LEN - 1));
    assign eop_accept = pkt_valid & pkt_ready & pkt_eop;
    assign seq_next   = pkt_seq + SEQ_WIDTH'(eop_accept);

`ifdef CPRI_PKT_HDR_EN
    logic [DATA_WIDTH-1:0] hdr_word;

    // seq_next so a header loaded right behind an accepted EOP carries the new number.
    assign hdr_word   = DATA_WIDTH'({16'hC5A0, 16'(seq_next), 16'(PKT_LEN)});
    assign start      = (avail >= AW'(PKT_LEN));
    assign fifo_rd_en = load_en & !fifo_empty & (state == StPayload);
`else
    assign start      = (avail >= AW'(PKT_LEN)) & !fifo_empty;
    assign fifo_rd_en = load_en & !fifo_empty & ((state == StPayload) | (state == StIdle & start));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            word_cnt     <= '0;
            pkt_data     <= '0;
            pkt_valid    <= 1'b0;
            pkt_sop      <= 1'b0;
            pkt_eop      <= 1'b0;
            pkt_seq      <= '0;
            underrun_err <= 1'b0;
        end else begin
            pkt_seq <= seq_next;
            if (load_en) begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            pkt_valid <= 1'b1;
                            pkt_sop   <= 1'b1;
                            pkt_eop   <= 1'b0;
                            state     <= StPayload;
`ifdef CPRI_PKT_HDR_EN
                            pkt_data  <= hdr_word;
                            word_cnt  <= '0;
`else
                            pkt_data  <= fifo_dout;
                            word_cnt  <= CW'(1);
`endif
                        end else begin
                            pkt_valid <= 1'b0;
                            pkt_sop   <= 1'b0;
                            pkt_eop   <= 1'b0;
                        end
                    end
                    StPayload: begin
                        if (!fifo_empty) begin
                            pkt_valid <= 1'b1;
                            pkt_sop   <= 1'b0;
                            pkt_data  <= fifo_dout;
                            if (last_word) begin
                                pkt_eop  <= 1'b1;
                                word_cnt <= '0;
                                state    <= StIdle;
                            end else begin
                                pkt_eop  <= 1'b0;
                                word_cnt <= word_cnt + CW'(1);
                            end
                        end else begin
                            // Committed packet starved: flag it and emit a bubble.
                            underrun_err <= 1'b1;
                            pkt_valid    <= 1'b0;
                            pkt_sop      <= 1'b0;
                            pkt_eop      <= 1'b0;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpri_pkt_framer.sv
// Directed bench for cpri_pkt_framer with a behavioural show-ahead FIFO in front of it.
// FIFO_DEPTH == PKT_LEN here so the packet start also exercises the usedw-wraps-at-full case.
module tb_cpri_pkt_framer;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned PLEN  = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned UW    = $clog2(DEPTH);
`ifdef CPRI_PKT_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NBEAT = PLEN + HDR;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic [UW-1:0] fifo_usedw;
    logic          fifo_rd_en;
    logic [DW-1:0] pkt_data;
    logic          pkt_valid;
    logic          pkt_sop;
    logic          pkt_eop;
    logic          pkt_ready;
    logic [SW-1:0] pkt_seq;
    logic          underrun_err;

    cpri_pkt_framer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .PKT_LEN   (PLEN),
        .SEQ_WIDTH (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_usedw  (fifo_usedw),
        .fifo_rd_en  (fifo_rd_en),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_sop     (pkt_sop),
        .pkt_eop     (pkt_eop),
        .pkt_ready   (pkt_ready),
        .pkt_seq     (pkt_seq),
        .underrun_err(underrun_err)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model; shares rst with the framer.
    logic [DW-1:0] mem [DEPTH];
    logic [UW-1:0] wp, rp;
    logic [UW:0]   cnt;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          force_empty;

    assign fifo_empty = (cnt == 0) || force_empty;
    assign fifo_full  = (cnt == (UW+1)'(DEPTH));
    assign fifo_usedw = cnt[UW-1:0];
    assign fifo_dout  = mem[rp];

    always @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 1'b1;
            end
            if (fifo_rd_en && !fifo_empty) rp <= rp + 1'b1;
            cnt <= cnt + (UW+1)'(wr_en) - (UW+1)'(fifo_rd_en && !fifo_empty);
        end
    end

    // Monitor: accepted beats, stall stability, and pops while empty.
    logic [DW-1:0] dq[$];
    bit            sq[$];
    bit            eq[$];
    int            hold_err = 0;
    int            rd_empty_err = 0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_sop, prev_eop;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend <= 1'b0;
        end else begin
            if (fifo_rd_en && fifo_empty) rd_empty_err <= rd_empty_err + 1;
            if (hold_pend && (pkt_valid !== 1'b1 || pkt_data !== prev_data ||
                              pkt_sop !== prev_sop || pkt_eop !== prev_eop))
                hold_err <= hold_err + 1;
            hold_pend <= pkt_valid && !pkt_ready;
            prev_data <= pkt_data;
            prev_sop  <= pkt_sop;
            prev_eop  <= pkt_eop;
            if (pkt_valid && pkt_ready) begin
                dq.push_back(pkt_data);
                sq.push_back(pkt_sop);
                eq.push_back(pkt_eop);
            end
        end
    end

    logic bp_mode = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bp_mode) pkt_ready = ~pkt_ready;
    end

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] next_val = 64'hA5A5_0000_0000_0100;
    logic [SW-1:0] exp_seq = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            wr_en   = 1'b1;
            wr_data = next_val;
            exp_q.push_back(next_val);
            next_val = next_val + 64'h11;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int cyc = 0;
        while (dq.size() < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (dq.size() < n) check("timeout_beats", 64'(dq.size()), 64'(n));
    endtask

    task automatic check_packet();
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        bit            s, l;
        wait_beats(NBEAT);
        if (dq.size() < NBEAT) return;
        for (int b = 0; b < NBEAT; b++) begin
            d = dq.pop_front();
            s = sq.pop_front();
            l = eq.pop_front();
            if (HDR == 1 && b == 0) e = {16'h0, 16'hC5A0, 16'(exp_seq), 16'(PLEN)};
            else e = exp_q.pop_front();
            check($sformatf("data[%0d]", b), d, e);
            check($sformatf("sop[%0d]", b), 64'(s), 64'(b == 0));
            check($sformatf("eop[%0d]", b), 64'(l), 64'(b == NBEAT - 1));
`ifdef CPRI_PKT_HDR_EN
            if (b == 0 && exp_seq == 5) check("hdr_seq5", d, 64'h0000_C5A0_0005_0020);
`endif
        end
        @(posedge clk);
        #1;
        exp_seq = exp_seq + 1'b1;
        check("seq", 64'(pkt_seq), 64'(exp_seq));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pkt_ready = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        force_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(pkt_valid), 0);
        check("rst_sop", 64'(pkt_sop), 0);
        check("rst_eop", 64'(pkt_eop), 0);
        check("rst_data", pkt_data, 0);
        check("rst_seq", 64'(pkt_seq), 0);
        check("rst_underrun", 64'(underrun_err), 0);
        check("rst_rd_en", 64'(fifo_rd_en), 0);
        rst = 1'b0;

        // Gating: 31 words must not start a packet; word 32 fills the FIFO (usedw reads 0).
        pkt_ready = 1'b1;
        push_words(PLEN - 1);
        repeat (5) @(negedge clk);
        check("gate_valid", 64'(pkt_valid), 0);
        check("gate_rd_en", 64'(fifo_rd_en), 0);
        check("gate_beats", 64'(dq.size()), 0);
        push_words(1);
        @(negedge clk);
        check("lat_pre_valid", 64'(pkt_valid), 0);
        @(negedge clk);
        check("lat_valid", 64'(pkt_valid), 1);
        check("lat_sop", 64'(pkt_sop), 1);
        check_packet();
        check("empty_after", 64'(fifo_empty), 1);
        #1;
        check("idle_valid", 64'(pkt_valid), 0);

        // Backpressure: ready toggles every cycle for two packets.
        bp_mode = 1'b1;
        push_words(PLEN);
        check_packet();
        push_words(PLEN);
        check_packet();
        bp_mode = 1'b0;
        @(posedge clk);
        #2;
        pkt_ready = 1'b1;
        check("bp_hold", 64'(hold_err), 0);

        // Sequence wrap: 17 packets in total take the 4-bit counter 15 -> 0 -> 1.
        for (int p = 0; p < 14; p++) begin
            push_words(PLEN);
            check_packet();
        end
        check("seq_wrap", 64'(pkt_seq), 1);

        // Underrun mid-packet.
        push_words(PLEN);
        wait_beats(5);
        @(posedge clk);
        #1;
        force_empty = 1'b1;
        repeat (2) @(negedge clk);
        check("ur_flag", 64'(underrun_err), 1);
        check("ur_valid", 64'(pkt_valid), 0);
        check("ur_rd_en", 64'(fifo_rd_en), 0);
        @(posedge clk);
        #1;
        force_empty = 1'b0;
        check_packet();
        check("ur_sticky", 64'(underrun_err), 1);
        check("rd_when_empty", 64'(rd_empty_err), 0);

        // Reset mid-packet.
        push_words(PLEN);
        wait_beats(4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_valid", 64'(pkt_valid), 0);
        check("mrst_sop", 64'(pkt_sop), 0);
        check("mrst_eop", 64'(pkt_eop), 0);
        check("mrst_data", pkt_data, 0);
        check("mrst_seq", 64'(pkt_seq), 0);
        check("mrst_underrun", 64'(underrun_err), 0);
        rst = 1'b0;
        dq.delete();
        sq.delete();
        eq.delete();
        exp_q.delete();
        exp_seq = '0;

        // Recovery after reset.
        push_words(PLEN);
        check_packet();
        check("final_hold", 64'(hold_err), 0);
        check("final_rd_when_empty", 64'(rd_empty_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
